trng_capture_buffer: RTL and testbench

- Parametrised successor to the single-channel TRNG capture/FIFO top.
- Combines NUM_CH entropy bit channels by XOR and packs the result MSB-first into WORD_W-bit words.
- Buffers up to DEPTH words in a circular store.
- On a button edge, drains the buffer over a valid/ready stream. Supports stop-when-full and ring (overwrite-oldest) modes, with sticky overflow reporting.

---
 rtl/trng_capture_buffer.sv | 238 +++++++++++++++++++++++
 tb/tb_trng_capture_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_capture_buffer.sv
// ---------------------------------------------------------------------------
// trng_capture_buffer
//
// Purpose:
//   Collects raw entropy from NUM_CH bit channels, whitens them by XOR into a
//   single bit per valid cycle, packs those bits MSB-first into WORD_W-bit
//   words and stores the words in a DEPTH-entry circular buffer.  A rising
//   edge on the button starts a drain of the buffer over a valid/ready
//   stream.  Two capture policies are offered: stop when the buffer is full
//   (entropy arriving while parked is reported as overflow) or ring mode,
//   where the oldest word is overwritten and overflow is reported.
//
// Parameters:
//   NUM_CH  number of entropy bit channels (>= 1)
//   WORD_W  packed word width (>= 2)
//   DEPTH   buffer depth in words (power of 2, >= 2)
//   CNT_W   width of the level output, log2(DEPTH)+1 (derived)
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   button       drain request (already synchronous), rising edge used
//   mode_ring    0 = stop capturing when full, 1 = overwrite oldest word
//   ent_valid    ent_bits carries a fresh sample this cycle
//   ent_bits     one raw entropy bit per channel
//   data_out     head word while draining, zero otherwise
//   data_valid   data_out holds a valid word
//   data_ready   consumer accepts data_out this cycle
//   full         buffer holds DEPTH words
//   empty        buffer holds no words
//   level        number of words stored
//   loading_out  high while capturing (FILL state)
//   overflow     sticky flag: entropy was lost since the last drain/reset
//   state        FILL=0, HOLD=1, DRAIN=2
// ---------------------------------------------------------------------------
module trng_capture_buffer #(
    parameter int NUM_CH = 4,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic              mode_ring,
    input  logic              ent_valid,
    input  logic [NUM_CH-1:0] ent_bits,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  level,
    output logic              loading_out,
    output logic              overflow,
    output logic [1:0]        state
);

    // Width of the bit counter inside the word being assembled.
    localparam int BC_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [PTR_W-1:0]    wrPtr_q,    wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q,    rdPtr_d;
    logic [CNT_W-1:0]    level_q,    level_d;
    logic [BC_W-1:0]     bcnt_q,     bcnt_d;
    // Only the low WORD_W-1 bits of the shift register are ever needed:
    // the final bit of a word is taken straight from the current sample.
    logic [WORD_W-2:0]   sh_q,       sh_d;
    logic                overflow_q, overflow_d;
    logic                btn_q;

    logic [WORD_W-1:0]   mem_q [DEPTH];

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic                entBit;
    logic [WORD_W-1:0]   packedWord;
    logic                lastBit;
    logic                btnEdge;
    logic                isFull;
    logic                isEmpty;
    logic                memWe;

    assign entBit     = ^ent_bits;
    assign packedWord = {sh_q, entBit};
    assign lastBit    = (bcnt_q == BC_W'(WORD_W - 1));
    assign btnEdge    = button & ~btn_q;
    assign isFull     = (level_q == CNT_W'(DEPTH));
    assign isEmpty    = (level_q == '0);

    // -----------------------------------------------------------------------
    // Next-state logic.  Pushes only happen in FILL and pops only in DRAIN,
    // so the level never has to handle a simultaneous push and pop.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        bcnt_d     = bcnt_q;
        sh_d       = sh_q;
        overflow_d = overflow_q;
        memWe      = 1'b0;

        unique case (state_q)
            FILL: begin
                // A drain request wins over the sample arriving in the same
                // cycle; that sample is simply dropped, not counted as loss.
                if (btnEdge && !isEmpty) begin
                    state_d    = DRAIN;
                    overflow_d = 1'b0;
                end else if (ent_valid) begin
                    sh_d   = packedWord[WORD_W-2:0];
                    bcnt_d = bcnt_q + BC_W'(1);
                    if (lastBit) begin
                        bcnt_d = '0;
                        if (!isFull) begin
                            memWe   = 1'b1;
                            wrPtr_d = wrPtr_q + PTR_W'(1);
                            level_d = level_q + CNT_W'(1);
                            if (!mode_ring && level_q == CNT_W'(DEPTH - 1)) begin
                                state_d = HOLD;
                            end
                        end else if (mode_ring) begin
                            // Overwrite the oldest word; the read pointer
                            // follows so the level stays at DEPTH.
                            memWe      = 1'b1;
                            wrPtr_d    = wrPtr_q + PTR_W'(1);
                            rdPtr_d    = rdPtr_q + PTR_W'(1);
                            overflow_d = 1'b1;
                        end else begin
                            // Full, and ring mode was turned off while still
                            // capturing: the completed word cannot be kept,
                            // so report the loss and park in HOLD.
                            overflow_d = 1'b1;
                            state_d    = HOLD;
                        end
                    end
                end
            end

            HOLD: begin
                // Parked on a full buffer.  The drain request has priority
                // over switching back to ring-mode capture.
                if (btnEdge) begin
                    state_d    = DRAIN;
                    overflow_d = 1'b0;
                end else begin
                    if (ent_valid) begin
                        overflow_d = 1'b1;
                    end
                    if (mode_ring) begin
                        state_d = FILL;
                    end
                end
            end

            DRAIN: begin
                // Entropy and further button edges are ignored here.  The
                // level is always non-zero in DRAIN, so the handshake alone
                // decides the pop.
                if (data_ready) begin
                    rdPtr_d = rdPtr_q + PTR_W'(1);
                    level_d = level_q - CNT_W'(1);
                    if (level_q == CNT_W'(1)) begin
                        state_d = FILL;
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers with synchronous reset.  The partial word (sh_q,
    // bcnt_q) survives HOLD and DRAIN and is only cleared by reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            bcnt_q     <= '0;
            sh_q       <= '0;
            overflow_q <= 1'b0;
            btn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            bcnt_q     <= bcnt_d;
            sh_q       <= sh_d;
            overflow_q <= overflow_d;
            btn_q      <= button;
        end
    end

    // -----------------------------------------------------------------------
    // Word storage.  The contents need no reset: the pointers and level
    // define which entries are meaningful.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && memWe) begin
            mem_q[wrPtr_q] <= packedWord;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs.  data_out is forced to zero outside DRAIN so the stream never
    // exposes stale buffer contents.
    // -----------------------------------------------------------------------
    assign data_valid  = (state_q == DRAIN);
    assign data_out    = data_valid ? mem_q[rdPtr_q] : '0;
    assign full        = isFull;
    assign empty       = isEmpty;
    assign level       = level_q;
    assign loading_out = (state_q == FILL);
    assign overflow    = overflow_q;
    assign state       = state_q;

endmodule

// File: tb/tb_trng_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_trng_capture_buffer
//
// Directed bench for trng_capture_buffer with NUM_CH=4, WORD_W=8, DEPTH=4.
// Inputs change 1 time unit after a rising clock edge and outputs are
// sampled at the same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_trng_capture_buffer;

    localparam int NUM_CH = 4;
    localparam int WORD_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst;
    logic              button;
    logic              mode_ring;
    logic              ent_valid;
    logic [NUM_CH-1:0] ent_bits;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  level;
    logic              loading_out;
    logic              overflow;
    logic [1:0]        state;

    int testsRun;
    int failCount;

    trng_capture_buffer #(
        .NUM_CH (NUM_CH),
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .mode_ring   (mode_ring),
        .ent_valid   (ent_valid),
        .ent_bits    (ent_bits),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .loading_out (loading_out),
        .overflow    (overflow),
        .state       (state)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one valid sample whose channel XOR equals b.  The low channels
    // are randomised so the XOR reduction itself is exercised.
    task automatic applyStimulus(input logic b);
        logic [2:0] r;
        r         = 3'($urandom_range(0, 7));
        ent_bits  = {b ^ (^r), r};
        ent_valid = 1'b1;
        tick();
        ent_valid = 1'b0;
        ent_bits  = '0;
    endtask

    // Feed a whole word, MSB first.
    task automatic feedWord(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(w[i]);
        end
    endtask

    // Single-cycle button pulse.
    task automatic pressButton();
        button = 1'b1;
        tick();
        button = 1'b0;
    endtask

    logic [7:0] ringWords [5];
    logic [7:0] bpWords   [4];

    initial begin
        testsRun   = 0;
        failCount  = 0;
        rst        = 1'b1;
        button     = 1'b0;
        mode_ring  = 1'b0;
        ent_valid  = 1'b0;
        ent_bits   = '0;
        data_ready = 1'b0;

        // ------------------------------------------------------------ 1
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_valid",    32'(data_valid),  32'h0);
        checkOutput("rst_data",     32'(data_out),    32'h0);
        checkOutput("rst_level",    32'(level),       32'h0);
        checkOutput("rst_empty",    32'(empty),       32'h1);
        checkOutput("rst_full",     32'(full),        32'h0);
        checkOutput("rst_loading",  32'(loading_out), 32'h1);
        checkOutput("rst_overflow", 32'(overflow),    32'h0);
        checkOutput("rst_state",    32'(state),       32'h0);

        // ------------------------------------------------------------ 2
        // Bits 1,0,1,1,0,0,1,0 pack to 8'hB2.
        applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
        applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("pack_level7", 32'(level), 32'h0);
        applyStimulus(1'b0);
        checkOutput("pack_level8", 32'(level), 32'h1);
        pressButton();
        checkOutput("pack_state_drain", 32'(state),      32'h2);
        checkOutput("pack_valid",       32'(data_valid), 32'h1);
        checkOutput("pack_data",        32'(data_out),   32'hB2);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        checkOutput("pack_empty",       32'(empty),      32'h1);
        checkOutput("pack_state_fill",  32'(state),      32'h0);
        checkOutput("pack_valid_off",   32'(data_valid), 32'h0);
        checkOutput("pack_data_off",    32'(data_out),   32'h0);

        // ------------------------------------------------------------ 3
        mode_ring = 1'b0;
        feedWord(8'h11);
        feedWord(8'h22);
        feedWord(8'h33);
        checkOutput("stop_level3", 32'(level), 32'h3);
        checkOutput("stop_state3", 32'(state), 32'h0);
        feedWord(8'h44);
        checkOutput("stop_full",     32'(full),        32'h1);
        checkOutput("stop_level",    32'(level),       32'h4);
        checkOutput("stop_state",    32'(state),       32'h1);
        checkOutput("stop_loading",  32'(loading_out), 32'h0);
        checkOutput("stop_ovf_pre",  32'(overflow),    32'h0);
        applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
        checkOutput("stop_overflow", 32'(overflow), 32'h1);
        checkOutput("stop_level_ov", 32'(level),    32'h4);
        mode_ring = 1'b1;
        tick();
        checkOutput("stop_to_fill",  32'(state),    32'h0);
        checkOutput("stop_ovf_keep", 32'(overflow), 32'h1);

        // ------------------------------------------------------------ 4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode_ring = 1'b1;
        ringWords[0] = 8'hA1; ringWords[1] = 8'hB2; ringWords[2] = 8'hC3;
        ringWords[3] = 8'hD4; ringWords[4] = 8'hE5;
        for (int i = 0; i < 4; i++) feedWord(ringWords[i]);
        checkOutput("ring_level4",  32'(level),    32'h4);
        checkOutput("ring_ovf_pre", 32'(overflow), 32'h0);
        checkOutput("ring_state",   32'(state),    32'h0);
        feedWord(ringWords[4]);
        checkOutput("ring_level",    32'(level),    32'h4);
        checkOutput("ring_overflow", 32'(overflow), 32'h1);
        pressButton();
        checkOutput("ring_drain",    32'(state),    32'h2);
        checkOutput("ring_ovf_clr",  32'(overflow), 32'h0);
        data_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            checkOutput($sformatf("ring_valid%0d", k), 32'(data_valid), 32'h1);
            checkOutput($sformatf("ring_word%0d", k),  32'(data_out),   32'(ringWords[k]));
            tick();
        end
        data_ready = 1'b0;
        checkOutput("ring_end_valid", 32'(data_valid), 32'h0);
        checkOutput("ring_end_data",  32'(data_out),   32'h0);
        checkOutput("ring_end_state", 32'(state),      32'h0);
        checkOutput("ring_end_empty", 32'(empty),      32'h1);

        // ------------------------------------------------------------ 5
        bpWords[0] = 8'h5A; bpWords[1] = 8'hC3; bpWords[2] = 8'h7E; bpWords[3] = 8'h19;
        for (int i = 0; i < 4; i++) feedWord(bpWords[i]);
        pressButton();
        checkOutput("bp_state", 32'(state), 32'h2);
        for (int k = 0; k < 4; k++) begin
            data_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
                button = (k == 0 && s == 1);
                if (k == 1) begin
                    applyStimulus(s[0]);
                end else begin
                    tick();
                end
                checkOutput($sformatf("bp_stall_valid%0d_%0d", k, s), 32'(data_valid), 32'h1);
                checkOutput($sformatf("bp_stall_data%0d_%0d", k, s),  32'(data_out),   32'(bpWords[k]));
            end
            button = 1'b0;
            checkOutput($sformatf("bp_ovf%0d", k), 32'(overflow), 32'h0);
            data_ready = 1'b1;
            tick();
            data_ready = 1'b0;
        end
        checkOutput("bp_end_state", 32'(state),    32'h0);
        checkOutput("bp_end_empty", 32'(empty),    32'h1);
        checkOutput("bp_end_ovf",   32'(overflow), 32'h0);
        // Mid-drain samples must not have advanced the bit counter:
        // exactly eight fresh bits complete the next word.
        for (int i = 7; i >= 1; i--) applyStimulus(bit'(8'h3C >> i));
        checkOutput("bp_bcnt_7", 32'(level), 32'h0);
        applyStimulus(1'b0);
        checkOutput("bp_bcnt_8", 32'(level), 32'h1);

        // ------------------------------------------------------------ 6
        feedWord(8'h81);
        feedWord(8'h42);
        feedWord(8'h24);
        checkOutput("rd_level", 32'(level), 32'h4);
        // Leave three bits of a partial word pending.
        applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b1);
        pressButton();
        checkOutput("rd_word0", 32'(data_out), 32'h3C);
        data_ready = 1'b1;
        tick();
        checkOutput("rd_word1", 32'(data_out), 32'h81);
        tick();
        data_ready = 1'b0;
        checkOutput("rd_level2", 32'(level),    32'h2);
        checkOutput("rd_word2",  32'(data_out), 32'h42);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rd_valid", 32'(data_valid), 32'h0);
        checkOutput("rd_data",  32'(data_out),   32'h0);
        checkOutput("rd_lvl0",  32'(level),      32'h0);
        checkOutput("rd_state", 32'(state),      32'h0);
        checkOutput("rd_empty", 32'(empty),      32'h1);
        // 8'h96 = 1,0,0,1,0,1,1,0
        applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b0);
        applyStimulus(1'b1); applyStimulus(1'b0);
        checkOutput("rd_partial_clear", 32'(level), 32'h0);
        applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b0);
        checkOutput("rd_fresh_word", 32'(level), 32'h1);
        pressButton();
        checkOutput("rd_fresh_data", 32'(data_out), 32'h96);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        checkOutput("rd_fresh_empty", 32'(empty), 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
